// File: rtl/i3c_hdr_ddr_pkg.sv
// Shared definitions for the HDR-DDR CRC5 path.
// The TX generator and the RX checker both import these, so they always agree
// on polynomial, seed and state encoding.
package i3c_hdr_ddr_pkg;

  // Low terms of x^5 + x^2 + 1; the x^5 term is implied by the shift-out.
  localparam logic [4:0] CRC5_POLY = 5'b00101;

  // Register value after init or reset.
  localparam logic [4:0] CRC5_SEED = 5'b11111;

  // Byte-serial CRC engine states.
  typedef enum logic [0:0] {
    CRC_IDLE  = 1'b0,
    CRC_SHIFT = 1'b1
  } crc_state_e;

endpackage

// File: rtl/crc5_bit_step.sv
// One CRC5 step: folds a single data bit into the running CRC.
// Purely combinational so TX and RX can wrap it in their own sequencing.
module crc5_bit_step #(
  parameter logic [4:0] POLY = 5'b00101
) (
  input  logic [4:0] crc_in,
  input  logic       din,
  output logic [4:0] crc_out
);

  logic fb;

  // Feedback is the bit shifted out of the top XOR the incoming data bit.
  assign fb = crc_in[4] ^ din;

  // Bit 0 receives a zero from the shift, so only the polynomial term remains.
  assign crc_out[0] = fb & POLY[0];

  // Upper bits take the next-lower bit, XORed with the polynomial when fed back.
  for (genvar gi = 1; gi < 5; gi++) begin : g_bit
    assign crc_out[gi] = crc_in[gi-1] ^ (fb & POLY[gi]);
  end

endmodule

// File: rtl/ddr_rx_crc5.sv
// RX-side CRC5 accumulator for HDR-DDR frames.
// Each byte strobed in by the deserializer is folded in one bit per cycle,
// MSB first. All outputs are registered one stage behind the internal state,
// so o_crc_value never follows inputs combinationally.
module ddr_rx_crc5
  import i3c_hdr_ddr_pkg::*;
#(
  parameter logic [4:0] CRC_POLY = CRC5_POLY,
  parameter logic [4:0] CRC_SEED = CRC5_SEED
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_crc_init,
  input  logic       i_rx_crc_en,
  input  logic       i_rx_crc_data_valid,
  input  logic [7:0] i_rx_data,
  output logic [4:0] o_crc_value,
  output logic       o_crc_valid,
  output logic       o_crc_busy,
  output logic       o_crc_overrun
);

  crc_state_e state_reg, state_next;
  logic [4:0] crc_reg, crc_next;
  logic [7:0] shreg_reg, shreg_next;
  logic [2:0] cnt_reg, cnt_next;
  logic       done_reg, done_next;
  logic       ov_reg, ov_next;
  logic [4:0] step_crc;
  logic       accept;

  // A strobe only counts while the deserializer has accumulation enabled.
  assign accept = i_rx_crc_en & i_rx_crc_data_valid;

  crc5_bit_step #(
    .POLY(CRC_POLY)
  ) u_step (
    .crc_in (crc_reg),
    .din    (shreg_reg[7]),
    .crc_out(step_crc)
  );

  // State register plus the output stage that trails the internal state by one cycle.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_reg     <= CRC_IDLE;
      crc_reg       <= CRC_SEED;
      shreg_reg     <= 8'h00;
      cnt_reg       <= 3'd0;
      done_reg      <= 1'b0;
      ov_reg        <= 1'b0;
      o_crc_value   <= CRC_SEED;
      o_crc_valid   <= 1'b0;
      o_crc_busy    <= 1'b0;
      o_crc_overrun <= 1'b0;
    end else begin
      state_reg     <= state_next;
      crc_reg       <= crc_next;
      shreg_reg     <= shreg_next;
      cnt_reg       <= cnt_next;
      done_reg      <= done_next;
      ov_reg        <= ov_next;
      o_crc_value   <= crc_reg;
      o_crc_valid   <= done_reg;
      o_crc_busy    <= (state_reg == CRC_SHIFT);
      o_crc_overrun <= ov_reg;
    end
  end

  // Next-state logic: init reseeds first, then a byte may be loaded on top of it.
  always_comb begin
    state_next = state_reg;
    crc_next   = crc_reg;
    shreg_next = shreg_reg;
    cnt_next   = cnt_reg;
    done_next  = done_reg;
    ov_next    = 1'b0;

    if (i_crc_init) begin
      state_next = CRC_IDLE;
      crc_next   = CRC_SEED;
      shreg_next = 8'h00;
      cnt_next   = 3'd0;
      done_next  = 1'b0;
    end

    case (state_reg)
      CRC_IDLE: begin
        if (accept) begin
          state_next = CRC_SHIFT;
          shreg_next = i_rx_data;
          cnt_next   = 3'd0;
          done_next  = 1'b0;
        end
      end
      CRC_SHIFT: begin
        if (i_crc_init) begin
          // Aborted byte; a simultaneous strobe starts fresh from the seed.
          if (accept) begin
            state_next = CRC_SHIFT;
            shreg_next = i_rx_data;
            cnt_next   = 3'd0;
          end
        end else begin
          // Finish the byte regardless of the enable; extra strobes are dropped.
          crc_next   = step_crc;
          shreg_next = {shreg_reg[6:0], 1'b0};
          cnt_next   = cnt_reg + 3'd1;
          ov_next    = accept;
          if (cnt_reg == 3'd7) begin
            state_next = CRC_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: begin
        state_next = CRC_IDLE;
      end
    endcase
  end

endmodule
